brushless: RTL

BRUSHLESS -- requirements
Module: brushless

---
 rtl/brushless.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/brushless.sv
// Hall-commutated brushless motor phase driver with brake, hall-fault FSM and registered outputs.
// Optional: define HALL_SEQ_CHK_EN to also flag samples that break the 101-100-110-010-011-001 rotation order.
module brushless (
    input  logic        clk,
    input  logic        rst,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic        brake_n,
    input  logic [11:0] drv_mag,
    input  logic        PWM_synch,
    output logic [10:0] duty,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic        hall_fault
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FAULT = 1'b1;

    logic [2:0]  r_hall_s1, r_hall_s2, r_rot;
    logic        r_brk_s1, r_brk_s2;
    logic [0:0]  r_state;
    logic        r_bad_cnt;
    logic [1:0]  r_good_cnt;
    logic        w_basic_ok, w_legal;
    logic [5:0]  w_sel;
    logic [10:0] w_duty;
    logic        w_fault;

    // Two-flop synchronizers; brake idles released so reset never looks like braking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hall_s1 <= 3'b000;
            r_hall_s2 <= 3'b000;
            r_brk_s1  <= 1'b1;
            r_brk_s2  <= 1'b1;
        end else begin
            r_hall_s1 <= {hallGrn, hallYlw, hallBlu};
            r_hall_s2 <= r_hall_s1;
            r_brk_s1  <= brake_n;
            r_brk_s2  <= r_brk_s1;
        end
    end

    assign w_basic_ok = (r_hall_s2 != 3'b000) && (r_hall_s2 != 3'b111);

`ifdef HALL_SEQ_CHK_EN
    logic [2:0] r_prev;
    logic       r_prev_vld;

    function automatic logic [2:0] seq_pos(input logic [2:0] h);
        case (h)
            3'b101:  seq_pos = 3'd0;
            3'b100:  seq_pos = 3'd1;
            3'b110:  seq_pos = 3'd2;
            3'b010:  seq_pos = 3'd3;
            3'b011:  seq_pos = 3'd4;
            3'b001:  seq_pos = 3'd5;
            default: seq_pos = 3'd7;
        endcase
    endfunction

    function automatic logic seq_step_ok(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] pa, pb, na, nb;
        pa = seq_pos(a);
        pb = seq_pos(b);
        na = (pa == 3'd5) ? 3'd0 : pa + 3'd1;
        nb = (pb == 3'd5) ? 3'd0 : pb + 3'd1;
        seq_step_ok = (pa == nb) || (pb == na);
    endfunction

    assign w_legal = w_basic_ok &&
                     (!r_prev_vld || (r_hall_s2 == r_prev) || seq_step_ok(r_hall_s2, r_prev));

    // Reference follows every non-000/111 sample so a jump is judged against where the rotor last was
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= 3'b000;
            r_prev_vld <= 1'b0;
        end else if (PWM_synch && w_basic_ok) begin
            r_prev     <= r_hall_s2;
            r_prev_vld <= 1'b1;
        end
    end
`else
    assign w_legal = w_basic_ok;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rot      <= 3'b000;
            r_state    <= RUN;
            r_bad_cnt  <= 1'b0;
            r_good_cnt <= 2'd0;
        end else if (PWM_synch) begin
            r_rot <= r_hall_s2;
            case (r_state)
                RUN: begin
                    if (!w_legal) begin
                        if (r_bad_cnt) begin
                            r_state    <= FAULT;
                            r_bad_cnt  <= 1'b0;
                            r_good_cnt <= 2'd0;
                        end else begin
                            r_bad_cnt <= 1'b1;
                        end
                    end else begin
                        r_bad_cnt <= 1'b0;
                    end
                end
                FAULT: begin
                    if (!w_legal) begin
                        r_good_cnt <= 2'd0;
                    end else if (r_good_cnt == 2'd3) begin
                        r_state    <= RUN;
                        r_good_cnt <= 2'd0;
                        r_bad_cnt  <= 1'b0;
                    end else begin
                        r_good_cnt <= r_good_cnt + 2'd1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // Output decode: FAULT overrides brake, brake overrides commutation
    always_comb begin
        w_sel   = 6'b00_00_00;
        w_duty  = 11'h000;
        w_fault = 1'b0;
        if (r_state == FAULT) begin
            w_fault = 1'b1;
        end else if (!r_brk_s2) begin
            w_sel  = 6'b11_11_11;
            w_duty = 11'h600;
        end else begin
            w_duty = 11'h400 + {1'b0, drv_mag[11:2]};
            case (r_rot)
                3'b101:  w_sel = 6'b10_01_00;
                3'b100:  w_sel = 6'b10_00_01;
                3'b110:  w_sel = 6'b00_10_01;
                3'b010:  w_sel = 6'b01_10_00;
                3'b011:  w_sel = 6'b01_00_10;
                3'b001:  w_sel = 6'b00_01_10;
                default: w_sel = 6'b00_00_00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            selGrn     <= 2'b00;
            selYlw     <= 2'b00;
            selBlu     <= 2'b00;
            duty       <= 11'h000;
            hall_fault <= 1'b0;
        end else begin
            selGrn     <= w_sel[5:4];
            selYlw     <= w_sel[3:2];
            selBlu     <= w_sel[1:0];
            duty       <= w_duty;
            hall_fault <= w_fault;
        end
    end

endmodule
